// File: rtl/cnn16_mem_if.sv
// CPU <-> main-memory request/response bundle for the CNN-16 processor.
//   master (CPU):    drives mem_req, mem_we, address, to_memory
//   slave  (memory): drives from_memory, mem_ready, busy
interface cnn16_mem_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] to_memory;
  logic [DATA_W-1:0] from_memory;
  logic              mem_ready;
  logic              busy;

  modport master (
    output mem_req, mem_we, address, to_memory,
    input  from_memory, mem_ready, busy
  );

  modport slave (
    input  mem_req, mem_we, address, to_memory,
    output from_memory, mem_ready, busy
  );
endinterface

// File: rtl/cnn16_mem_ctrl.sv
// Wait-stated single-port main memory for the CNN-16 processor.
//   clk, reset (sync, active-low)
//   bus       : CPU request/response (slave side of cnn16_mem_if)
//   init_we/init_addr/init_data : host preload port, honoured only while idle
//   init_err  : sticky flag, an init write was dropped
module cnn16_mem_ctrl #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  cnn16_mem_if.slave        bus,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture;
  logic              rd_load;
  logic              init_drop;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic [DATA_W-1:0] mem [DEPTH];

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bus.from_memory <= '0;
      bus.mem_ready   <= 1'b0;
      bus.busy        <= 1'b0;
      init_err        <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.mem_ready <= (state_nxt == ST_RESP);
      bus.busy      <= (state_nxt != ST_IDLE);
      if (rd_load) bus.from_memory <= mem[lat_addr];
      if (init_drop) init_err <= 1'b1;
    end
  end

  // Request capture; later input changes are ignored
  always_ff @(posedge clk) begin
    if (capture) begin
      lat_we   <= bus.mem_we;
      lat_addr <= bus.address;
      lat_data <= bus.to_memory;
    end
  end

  // Array write port, shared by init and CPU writes (never active together);
  // gated by reset so an abandoned transaction cannot land
  always_ff @(posedge clk) begin
    if (reset && arr_we) mem[arr_waddr] <= arr_wdata;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    rd_load   = 1'b0;
    init_drop = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = init_addr;
    arr_wdata = init_data;

    // Init writes only while idle with no competing CPU request
    if (init_we) begin
      if (state == ST_IDLE && !bus.mem_req) arr_we = 1'b1;
      else                                  init_drop = 1'b1;
    end

    unique case (state)
      ST_IDLE: begin
        if (bus.mem_req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_ACCESS;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_ACCESS;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_ACCESS: begin
        if (lat_we) begin
          arr_we    = 1'b1;
          arr_waddr = lat_addr;
          arr_wdata = lat_data;
        end else begin
          rd_load = 1'b1;
        end
        state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
